// File: rtl/axil_sram_pkg.sv
// Shared types and address-decode helpers for the AXI-Lite SRAM slave.
package axil_sram_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    // Arguments are widened to 64 bits so one helper serves every ADDR_WIDTH.
    function automatic logic [63:0] word_index(input logic [63:0] addr,
                                               input logic [63:0] base,
                                               input int          shift);
        return (addr - base) >> shift;
    endfunction

    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] size_bytes);
        return (addr >= base) && ((addr - base) < size_bytes);
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle; the slave only uses the signals listed in the Slave modport.
interface AXI_LITE #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      aw_valid;
    logic                      aw_ready;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;
    logic                      b_valid;
    logic                      b_ready;
    logic [1:0]                b_resp;
    logic                      ar_valid;
    logic                      ar_ready;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic                      r_valid;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;

    modport Slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid,
               r_data, r_resp
    );

    modport Master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid,
               r_data, r_resp
    );
endinterface

// File: rtl/axil_sram_array.sv
// 1R1W synchronous SRAM with per-byte write enables and registered read data.
// Read-before-write on collision; drop-in replaceable by a vendor macro.
module axil_sram_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Both ports use non-blocking updates, so a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axil_sram_slave.sv
// AXI-Lite slave over an inferred SRAM: decoupled AW/W hold registers,
// single-cycle read latency, SLVERR for addresses outside the window.
module axil_sram_slave
    import axil_sram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [31:0]           ERR_DATA   = 32'habadf00d
) (
    input  logic   aclk,
    input  logic   areset,
    AXI_LITE.Slave slv
);
    localparam int                    STRB_W     = DATA_WIDTH / 8;
    localparam int                    OFF_W      = $clog2(STRB_W);
    localparam int                    IDX_W      = $clog2(DEPTH);
    localparam logic [63:0]           SIZE_BYTES = 64'(DEPTH) * 64'(STRB_W);
    localparam logic [DATA_WIDTH-1:0] ERR_D      = DATA_WIDTH'(ERR_DATA);

    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  b_valid_q, b_valid_d;
    resp_e                 b_resp_q, b_resp_d;
    logic                  r_valid_q, r_valid_d;
    resp_e                 r_resp_q, r_resp_d;

    logic                  aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
    logic [IDX_W-1:0]      waddr, raddr;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign slv.aw_ready = ~aw_held_q & ~areset;
    assign slv.w_ready  = ~w_held_q & ~areset;
    assign slv.ar_ready = (~r_valid_q | slv.r_ready) & ~areset;

    assign aw_hs  = slv.aw_valid & slv.aw_ready;
    assign w_hs   = slv.w_valid & slv.w_ready;
    assign ar_hs  = slv.ar_valid & slv.ar_ready;
    // A pending B response blocks the next commit, giving in-order B beats.
    assign commit = aw_held_q & w_held_q & ~b_valid_q;

    assign wr_ok = in_range(64'(aw_addr_q), 64'(BASE_ADDR), SIZE_BYTES);
    assign rd_ok = in_range(64'(slv.ar_addr), 64'(BASE_ADDR), SIZE_BYTES);
    assign waddr = IDX_W'(word_index(64'(aw_addr_q), 64'(BASE_ADDR), OFF_W));
    assign raddr = IDX_W'(word_index(64'(slv.ar_addr), 64'(BASE_ADDR), OFF_W));

    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        r_valid_d = r_valid_q;
        r_resp_d  = r_resp_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = slv.aw_addr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = slv.w_data;
            w_strb_d = slv.w_strb;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = wr_ok ? OKAY : SLVERR;
        end else if (b_valid_q && slv.b_ready) begin
            b_valid_d = 1'b0;
        end

        if (ar_hs) begin
            r_valid_d = 1'b1;
            r_resp_d  = rd_ok ? OKAY : SLVERR;
        end else if (r_valid_q && slv.r_ready) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= OKAY;
            r_valid_q <= 1'b0;
            r_resp_q  <= OKAY;
        end else begin
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_valid_q <= b_valid_d;
            b_resp_q  <= b_resp_d;
            r_valid_q <= r_valid_d;
            r_resp_q  <= r_resp_d;
        end
    end

    axil_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (aclk),
        .we    (commit & wr_ok & ~areset),
        .waddr (waddr),
        .wdata (w_data_q),
        .wstrb (w_strb_q),
        .re    (ar_hs),
        .raddr (raddr),
        .rdata (arr_rdata)
    );

    assign slv.b_valid = b_valid_q;
    assign slv.b_resp  = b_resp_q;
    assign slv.r_valid = r_valid_q;
    assign slv.r_resp  = r_resp_q;
    // The array output register is not reset, so mask it while no beat is valid.
    assign slv.r_data  = !r_valid_q          ? '0    :
                         (r_resp_q == SLVERR) ? ERR_D : arr_rdata;

endmodule
